// File: rtl/counter_pkg.sv
// Shared constants and helpers for the multimode counter.
package counter_pkg;

    // Ceiling log2, used to size the prescaler phase register.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int CNT_W_DEFAULT = 5;

    // Boundary behaviour selected by the saturate input.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Count direction selected by the up input.
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits one tick every Prescale enabled cycles.
// With Prescale==1 the phase register is bypassed and tick follows enable.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int Prescale = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    generate
        if (Prescale == 1) begin : g_bypass
            assign tick = enable & ~restart;
        end else begin : g_div
            localparam int PH_W = clog2(Prescale);
            localparam logic [PH_W-1:0] LAST = PH_W'(Prescale - 1);

            logic [PH_W-1:0] phase;

            assign tick = enable & ~restart & (phase == LAST);

            // Phase advances on enable, wraps on the step cycle, holds otherwise.
            always_ff @(posedge clock) begin
                if (reset || restart)
                    phase <= '0;
                else if (enable)
                    phase <= (phase == LAST) ? '0 : phase + 1'b1;
            end
        end
    endgenerate

endmodule

// File: rtl/counter_multimode.sv
// Up/down counter with programmable modulus, wrap/saturate modes, parallel
// load, prescaled stepping, registered terminal-count pulse and sticky overflow.
module counter_multimode
    import counter_pkg::*;
#(
    parameter int Size     = CNT_W_DEFAULT,
    parameter int Modulus  = 2 ** Size,
    parameter int Prescale = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            up,
    input  logic            saturate,
    input  logic            load,
    input  logic [Size-1:0] load_value,
    input  logic            clear_flags,
    output logic [Size-1:0] count,
    output logic            tc,
    output logic            overflow
);

    localparam int W1 = Size + 1;
    localparam logic [W1-1:0]   MOD_EXT = W1'(Modulus);
    localparam logic [W1-1:0]   MAX_EXT = W1'(Modulus - 1);
    localparam logic [Size-1:0] MAX     = Size'(Modulus - 1);

    logic            tick;
    logic [W1-1:0]   cnt_ext;
    logic [W1-1:0]   inc;
    logic [W1-1:0]   dec;
    logic            at_max;
    logic            at_min;
    logic            boundary;
    logic [Size-1:0] step_val;
    logic [Size-1:0] load_clamped;

    counter_prescaler #(.Prescale(Prescale)) u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .restart (load),
        .tick    (tick)
    );

    // Next-count candidates and boundary detect, all in Size+1 bits so the
    // carry/borrow and the load clamp compare never alias.
    always_comb begin
        cnt_ext      = {1'b0, count};
        inc          = cnt_ext + 1'b1;
        dec          = cnt_ext - 1'b1;
        at_max       = (inc == MOD_EXT);
        at_min       = dec[Size];
        boundary     = tick & ((up == DIR_UP) ? at_max : at_min);
        step_val     = count;
        if (up == DIR_UP)
            step_val = at_max ? ((saturate == MODE_SAT) ? MAX : '0) : inc[Size-1:0];
        else
            step_val = at_min ? ((saturate == MODE_SAT) ? '0 : MAX) : dec[Size-1:0];
        load_clamped = ({1'b0, load_value} > MAX_EXT) ? MAX : load_value;
    end

    // Count register: reset > load > step > hold.
    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_clamped;
        else if (tick)
            count <= step_val;
    end

    // Terminal-count pulse aligned with the count that follows a boundary step.
    always_ff @(posedge clock) begin
        if (reset)
            tc <= 1'b0;
        else
            tc <= boundary;
    end

    // Sticky overflow; a boundary in the same cycle as clear_flags keeps it set.
    always_ff @(posedge clock) begin
        if (reset)
            overflow <= 1'b0;
        else if (boundary)
            overflow <= 1'b1;
        else if (clear_flags)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_counter_multimode.sv
// Self-checking bench: directed scenarios plus random stimulus, both DUT
// variants (Prescale 1 and 3, Modulus 20) compared against an integer model.
module tb_counter_multimode;

    localparam int MOD = 20;

    logic       clock = 1'b0;
    logic       reset, enable, up, saturate, load, clear_flags;
    logic [4:0] load_value;
    logic [4:0] count1, count3;
    logic       tc1, tc3, ovf1, ovf3;

    int n_chk  = 0;
    int n_fail = 0;

    int m_cnt [2];
    int m_pre [2];
    bit m_tc  [2];
    bit m_ovf [2];

    int exp4 [9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

    always #5 clock = ~clock;

    counter_multimode #(.Size(5), .Modulus(MOD), .Prescale(1)) d1 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .load(load), .load_value(load_value), .clear_flags(clear_flags),
        .count(count1), .tc(tc1), .overflow(ovf1)
    );

    counter_multimode #(.Size(5), .Modulus(MOD), .Prescale(3)) d3 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .load(load), .load_value(load_value), .clear_flags(clear_flags),
        .count(count3), .tc(tc3), .overflow(ovf3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reference for instance k (0: Prescale 1, 1: Prescale 3).
    task automatic model(input int k);
        int ps;
        bit b;
        ps = (k == 0) ? 1 : 3;
        b  = 1'b0;
        if (reset) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
        end else begin
            if (load) begin
                m_cnt[k] = (int'(load_value) > MOD - 1) ? MOD - 1 : int'(load_value);
                m_pre[k] = 0;
            end else if (enable) begin
                if (m_pre[k] == ps - 1) begin
                    m_pre[k] = 0;
                    if (up) begin
                        if (m_cnt[k] == MOD - 1) begin
                            b = 1'b1;
                            if (!saturate) m_cnt[k] = 0;
                        end else m_cnt[k] = m_cnt[k] + 1;
                    end else begin
                        if (m_cnt[k] == 0) begin
                            b = 1'b1;
                            if (!saturate) m_cnt[k] = MOD - 1;
                        end else m_cnt[k] = m_cnt[k] - 1;
                    end
                end else m_pre[k] = m_pre[k] + 1;
            end
            m_tc[k] = b;
            if (b) m_ovf[k] = 1'b1;
            else if (clear_flags) m_ovf[k] = 1'b0;
        end
    endtask

    // One clock: update the model with the current inputs, check 1 unit later.
    task automatic cyc();
        @(posedge clock);
        model(0);
        model(1);
        #1;
        chk("cnt1", count1, m_cnt[0]);
        chk("tc1",  tc1,    m_tc[0]);
        chk("ovf1", ovf1,   m_ovf[0]);
        chk("cnt3", count3, m_cnt[1]);
        chk("tc3",  tc3,    m_tc[1]);
        chk("ovf3", ovf3,   m_ovf[1]);
    endtask

    task automatic idle();
        reset = 0; enable = 0; up = 1; saturate = 0;
        load = 0; load_value = '0; clear_flags = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        cyc();
        chk("rst_cnt", count1, 0);
        chk("rst_ovf", ovf1, 0);

        // Wrap up through the modulus.
        idle(); enable = 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("t1_cnt", count1, (i + 1) % MOD);
            chk("t1_tc",  tc1, (i == 19) ? 1 : 0);
        end
        chk("t1_ovf", ovf1, 1);

        // Load then saturate downward.
        idle(); load = 1; load_value = 5'd3;
        cyc();
        chk("t2_load", count1, 3);
        idle(); enable = 1; up = 0; saturate = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_cnt", count1, (i < 3) ? 2 - i : 0);
            chk("t2_tc",  tc1, (i >= 3) ? 1 : 0);
        end

        // Out-of-range load clamps, next up step wraps.
        idle(); load = 1; load_value = 5'd25;
        cyc();
        chk("t3_clamp", count1, MOD - 1);
        idle(); enable = 1;
        cyc();
        chk("t3_wrap", count1, 0);
        chk("t3_tc", tc1, 1);

        // Prescale 3 stepping, enable gaps keep the phase.
        idle(); reset = 1;
        cyc();
        idle(); enable = 1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("t4_cnt", count3, exp4[i]);
        end
        enable = 1; cyc();
        enable = 0; cyc(); cyc();
        chk("t4_hold", count3, 3);
        enable = 1; cyc();
        chk("t4_res1", count3, 3);
        cyc();
        chk("t4_res2", count3, 4);

        // Clear racing a boundary event, then clear alone.
        idle(); load = 1; load_value = 5'd19;
        cyc();
        idle(); enable = 1; clear_flags = 1;
        cyc();
        chk("t5_race", ovf1, 1);
        idle(); clear_flags = 1;
        cyc();
        chk("t5_clr", ovf1, 0);

        // Reset beats load and enable mid-count; prescaler restarts at phase 0.
        idle(); enable = 1;
        cyc(); cyc(); cyc(); cyc();
        reset = 1; load = 1; load_value = 5'd7;
        cyc();
        chk("t6_cnt", count3, 0);
        chk("t6_tc", tc1, 0);
        idle(); enable = 1;
        cyc(); cyc();
        chk("t6_ph", count3, 0);
        cyc();
        chk("t6_step", count3, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            load        = ($urandom_range(0, 7) == 0);
            enable      = ($urandom_range(0, 3) != 0);
            clear_flags = ($urandom_range(0, 7) == 0);
            up          = 1'($urandom);
            saturate    = 1'($urandom);
            load_value  = 5'($urandom_range(0, 31));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
